// File: rtl/vip_uart_pkg.sv
// Shared UART verification-IP definitions: the receiver FSM state encoding
// and frame constants used by vip_uart_receiver.
// No ports; imported by the receiver.
package vip_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_rx_state_e;

endpackage

// File: rtl/vip_uart_receiver.sv
// UART 8N1 receiver for capturing a DUT's TX line; oversamples by `scaler` clocks per bit.
// Ports: i_clk/i_nrst clock and async active-low reset; i_rx serial input (idle high);
//        o_rdy byte-valid pulse, o_rdata last good byte, o_err_stop framing-error pulse, o_busy not idle.
module vip_uart_receiver
  import vip_uart_pkg::*;
#(
  parameter int scaler  = 8,
  parameter int instnum = 0
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_rx,
  output logic       o_rdy,
  output logic [7:0] o_rdata,
  output logic       o_err_stop,
  output logic       o_busy
);

  localparam int CW = $clog2(scaler);
  localparam logic [CW-1:0] CNT_HALF = CW'(scaler / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(scaler - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

  uart_rx_state_e state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     rdata_q, rdata_d;
  logic           rdy_q, rdy_d;
  logic           err_q, err_d;
  logic           sync1_q, sync2_q;
  logic           rxs;

  assign rxs = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    rdata_d = rdata_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        // Re-check the line half a bit in: a short low pulse is treated as a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_FULL) begin
          // LSB arrives first, so shifting right leaves bit 0 in shift[0] after 8 samples.
          shift_d = {rxs, shift_q[7:1]};
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == IDX_LAST) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rxs) begin
            rdata_d = shift_q;
            rdy_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_BREAK: begin
        // A held-low line must return high before another start can be seen.
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
    end
  end

  assign o_rdy      = rdy_q;
  assign o_rdata    = rdata_q;
  assign o_err_stop = err_q;
  assign o_busy     = (state_q != ST_IDLE);

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (rdy_q) begin
      if (rdata_q >= 8'h20 && rdata_q < 8'h7f)
        $display("vip_uart_receiver[%0d]: rx '%c'", instnum, rdata_q);
      else
        $display("vip_uart_receiver[%0d]: rx 0x%02h", instnum, rdata_q);
    end
  end
`endif

endmodule

// File: tb/tb_vip_uart_receiver.sv
// Bench for vip_uart_receiver (scaler=8): table of good frames plus hand-written
// glitch, framing-error/break, back-to-back and mid-frame reset sequences.
module tb_vip_uart_receiver;

  logic       clk;
  logic       nrst;
  logic       rx;
  logic       rdy;
  logic [7:0] rdata;
  logic       err_stop;
  logic       busy;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int overlap = 0;

  int         rdy_cyc[$];
  logic [7:0] rdy_dat[$];
  int         err_cyc[$];

  vip_uart_receiver #(.scaler(8), .instnum(0)) dut (
    .i_clk      (clk),
    .i_nrst     (nrst),
    .i_rx       (rx),
    .o_rdy      (rdy),
    .o_rdata    (rdata),
    .o_err_stop (err_stop),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (rdy) begin
      rdy_cyc.push_back(cyc);
      rdy_dat.push_back(rdata);
    end
    if (err_stop) err_cyc.push_back(cyc);
    if (rdy && err_stop) overlap = overlap + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_rdata;
    int         exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_events();
    @(posedge clk);
    rdy_cyc.delete();
    rdy_dat.delete();
    err_cyc.delete();
  endtask

  // Drives start bit, 8 data bits LSB first, then the given stop bit, 8 clocks each.
  // start_edge is the cycle number of the first edge that sees rx low.
  task automatic send_frame(input logic [7:0] d, input logic stopb, output int start_edge);
    logic [9:0] f;
    f = {stopb, d, 1'b0};
    start_edge = 0;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        if (i == 0 && j == 0) start_edge = cyc + 1;
        rx = f[i];
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  initial begin
    int s0, s1, busy_cnt;
    logic [7:0] held;

    vecs[0] = '{8'h55, 8'h55, 78};
    vecs[1] = '{8'h00, 8'h00, 78};
    vecs[2] = '{8'hFF, 8'hFF, 78};
    vecs[3] = '{8'h41, 8'h41, 78};
    vecs[4] = '{8'h12, 8'h12, 78};
    vecs[5] = '{8'h80, 8'h80, 78};
    vecs[6] = '{8'h01, 8'h01, 78};
    vecs[7] = '{8'hA5, 8'hA5, 78};

    rx   = 1'b1;
    nrst = 1'b0;
    #1;
    check("reset_rdy",   int'(rdy), 0);
    check("reset_err",   int'(err_stop), 0);
    check("reset_busy",  int'(busy), 0);
    check("reset_rdata", int'(rdata), 0);
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    idle(5);

    // Table of well-formed frames.
    for (int v = 0; v < 8; v++) begin
      clear_events();
      send_frame(vecs[v].data, 1'b1, s0);
      idle(10);
      check($sformatf("vec%0d_rdy_count", v), rdy_cyc.size(), 1);
      check($sformatf("vec%0d_err_count", v), err_cyc.size(), 0);
      if (rdy_cyc.size() > 0) begin
        check($sformatf("vec%0d_latency", v), rdy_cyc[0] - s0, vecs[v].exp_lat);
        check($sformatf("vec%0d_data", v), int'(rdy_dat[0]), int'(vecs[v].exp_rdata));
      end
      check($sformatf("vec%0d_rdata_held", v), int'(rdata), int'(vecs[v].exp_rdata));
    end

    // Start glitch: 3 low cycles must be rejected.
    clear_events();
    busy_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx = 1'b0;
      if (busy) busy_cnt++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx = 1'b1;
      if (busy) busy_cnt++;
    end
    check("glitch_rdy_count", rdy_cyc.size(), 0);
    check("glitch_err_count", err_cyc.size(), 0);
    check("glitch_busy_3to4", int'(busy_cnt >= 3 && busy_cnt <= 4), 1);
    check("glitch_rdata_held", int'(rdata), 8'hA5);

    // Framing error followed by a held-low break, then recovery.
    clear_events();
    send_frame(8'hA3, 1'b0, s0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    check("ferr_err_count", err_cyc.size(), 1);
    if (err_cyc.size() > 0) check("ferr_latency", err_cyc[0] - s0, 78);
    check("ferr_rdy_count", rdy_cyc.size(), 0);
    check("ferr_rdata_held", int'(rdata), 8'hA5);
    check("ferr_break_busy", int'(busy), 1);
    idle(6);
    check("break_exit_busy", int'(busy), 0);
    clear_events();
    send_frame(8'h41, 1'b1, s0);
    idle(10);
    check("after_break_rdy_count", rdy_cyc.size(), 1);
    if (rdy_dat.size() > 0) check("after_break_data", int'(rdy_dat[0]), 8'h41);

    // Back-to-back frames with no idle gap.
    clear_events();
    send_frame(8'h00, 1'b1, s0);
    send_frame(8'hFF, 1'b1, s1);
    idle(10);
    check("b2b_rdy_count", rdy_cyc.size(), 2);
    check("b2b_err_count", err_cyc.size(), 0);
    if (rdy_cyc.size() == 2) begin
      check("b2b_spacing", rdy_cyc[1] - rdy_cyc[0], 80);
      check("b2b_data0", int'(rdy_dat[0]), 8'h00);
      check("b2b_data1", int'(rdy_dat[1]), 8'hFF);
    end

    // Reset pulse in the middle of the data bits; held until the stop bit so the
    // low bit 7 of 0x7E cannot be mistaken for a new start bit.
    clear_events();
    held = rdata;
    check("pre_reset_rdata", int'(held), 8'hFF);
    fork
      send_frame(8'h7E, 1'b1, s0);
      begin
        repeat (40) @(posedge clk);
        #1 nrst = 1'b0;
        #1;
        check("midrst_rdy",   int'(rdy), 0);
        check("midrst_err",   int'(err_stop), 0);
        check("midrst_busy",  int'(busy), 0);
        check("midrst_rdata", int'(rdata), 0);
        repeat (34) @(posedge clk);
        #1 nrst = 1'b1;
      end
    join
    idle(60);
    check("midrst_no_rdy", rdy_cyc.size(), 0);
    check("midrst_no_err", err_cyc.size(), 0);
    clear_events();
    send_frame(8'h12, 1'b1, s0);
    idle(10);
    check("post_rst_rdy_count", rdy_cyc.size(), 1);
    if (rdy_cyc.size() > 0) begin
      check("post_rst_latency", rdy_cyc[0] - s0, 78);
      check("post_rst_data", int'(rdy_dat[0]), 8'h12);
    end

    check("rdy_err_exclusive", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/vip_uart_receiver.md
VIP_UART_RECEIVER -- requirements
Module: vip_uart_receiver

Interface
REQ-001 Parameter scaler, default 8: clock cycles per UART bit; even, minimum 4.
REQ-002 Parameter instnum, default 0: instance index, reported in simulation messages only.
REQ-003 i_clk  input  1: sole clock; frequency = baudrate*scaler; all logic on rising edge.
REQ-004 i_nrst  input  1: reset, asynchronous, active-low.
REQ-005 i_rx  input  1: serial line from DUT UART TX; idle high; 8N1, LSB first.
REQ-006 o_rdy  output  1: one-cycle pulse, valid byte on o_rdata.
REQ-007 o_rdata  output  8: last correctly framed byte; held until the next valid frame.
REQ-008 o_err_stop  output  1: one-cycle pulse, stop bit sampled low (framing error).
REQ-009 o_busy  output  1: high in any state other than IDLE.

Function
REQ-010 i_rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); the FSM uses only the synchronized value rxs.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP and BREAK.
REQ-012 Bit counter cnt width SHALL be $clog2(scaler); bit index idx SHALL be 3 bits.
REQ-013 IDLE: rxs=0 -> START, cnt=0; otherwise stay.
REQ-014 START: cnt increments each cycle; at cnt=scaler/2-1, rxs=0 -> DATA with cnt=0, idx=0; rxs=1 -> IDLE (glitch rejected, no output).
REQ-015 DATA: cnt increments; at cnt=scaler-1, shift rxs into shift[7] (right shift), cnt=0, idx+1; after the 8th sample -> STOP.
REQ-016 STOP: at cnt=scaler-1, rxs=1 -> o_rdata<=shift, o_rdy=1 for one cycle, -> IDLE; rxs=0 -> o_err_stop=1 for one cycle, o_rdata unchanged, -> BREAK.
REQ-017 BREAK: remain until rxs=1, then -> IDLE; no new start detection while in BREAK.
REQ-018 Latency: with edge 0 = first edge sampling i_rx low, o_rdy/o_err_stop SHALL be high in the cycle after edge 2+scaler/2+9*scaler (78 for scaler=8).
REQ-019 A start bit arriving immediately after the stop sample SHALL be detected without lost frames; back-to-back frames SHALL be supported.
REQ-020 o_rdy and o_err_stop SHALL never be high in the same cycle.
REQ-021 On every o_rdy, a $display line SHALL print instnum and the byte (printable char or hex).

Reset
REQ-022 Asserting i_nrst low at any time, including mid-frame, SHALL immediately set: state=IDLE, cnt=0, idx=0, shift=0, o_rdata=0, o_rdy=0, o_err_stop=0, o_busy=0, sync flops=1.
REQ-023 After reset release, a partial frame in progress SHALL NOT produce o_rdy.

Structure
REQ-024 The FSM state enum and a UART_DATA_BITS=8 constant SHALL live in the shared package vip_uart_pkg.
REQ-025 No sub-module is required; synchronizer, FSM and shift register SHALL be in one module, all registers in one async-reset always_ff block.

Verification
REQ-026 scaler=8, frame 0x55 -> single o_rdy in the cycle after edge 78, o_rdata=0x55, o_err_stop stays 0.
REQ-027 i_rx low for 3 cycles then high -> START->IDLE, no o_rdy, no o_err_stop, o_busy high 3-4 cycles.
REQ-028 Frame 0xA3 with stop bit 0, then line held low 40 cycles -> o_err_stop pulse, o_rdata unchanged, state BREAK until high, next frame 0x41 -> o_rdy with 0x41.
REQ-029 Back-to-back 0x00 then 0xFF with zero idle gap -> two o_rdy pulses exactly 80 cycles apart, data 0x00 then 0xFF.
REQ-030 i_nrst pulsed low at mid-DATA of 0x7E -> all outputs 0 immediately, no o_rdy for that frame; next 0x12 -> o_rdy with 0x12.
REQ-031 Top-level: capture boot text from the DUT UART at the sped-up baud rate and check that the received string matches the expected banner.
